// File: rtl/e1ofn_rtl_bridge.sv
// e1ofn_rtl_bridge: bridges QDI e1ofN four-phase channels (M digits of 1-of-N rails) to
// clocked valid/ready ports. One receive path (rails -> rcv_*) and one send path
// (snd_* -> rails), fully independent.
// Optional feature: define E1OFN_RAIL_CHECK_EN to enable the sticky rail_err protocol checker;
// when undefined rail_err is tied low.
module e1ofn_rtl_bridge #(
  parameter int unsigned M = 9,
  parameter int unsigned N = 2,
  localparam int unsigned B = $clog2(N),
  localparam int unsigned W = M * B
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [M*N-1:0] in_d,
  output logic           in_e,
  output logic [W-1:0]   rcv_data,
  output logic           rcv_valid,
  input  logic           rcv_ready,
  input  logic [W-1:0]   snd_data,
  input  logic           snd_valid,
  output logic           snd_ready,
  output logic [M*N-1:0] out_d,
  input  logic           out_e,
  output logic           rail_err
);

  typedef enum logic {RxIdle, RxFull} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxWaitE, TxData, TxNull} tx_state_e;

  logic [M*N-1:0] in_s1_q, in_s2_q;
  logic           out_e_s1_q, out_e_s2_q;

  rx_state_e      rx_state_q, rx_state_d;
  logic           rcv_valid_q, rcv_valid_d;
  logic [W-1:0]   rcv_data_q, rcv_data_d;

  tx_state_e      tx_state_q, tx_state_d;
  logic [W-1:0]   snd_q, snd_d;
  logic [M*N-1:0] out_d_q, out_d_d;

  logic [W-1:0]   dec_data;
  logic           tok_valid;
  logic           neutral;
  logic [M*N-1:0] out_enc;

  // Two-flop synchronizers for the asynchronous rails and the send-side enable.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      in_s1_q    <= '0;
      in_s2_q    <= '0;
      out_e_s1_q <= 1'b0;
      out_e_s2_q <= 1'b0;
    end else begin
      in_s1_q    <= in_d;
      in_s2_q    <= in_s1_q;
      out_e_s1_q <= out_e;
      out_e_s2_q <= out_e_s1_q;
    end
  end

  // Decode synced rails: a token is valid only when every digit has exactly one rail high.
  always_comb begin
    int unsigned cnt;
    cnt       = 0;
    dec_data  = '0;
    tok_valid = 1'b1;
    for (int i = 0; i < int'(M); i++) begin
      cnt = 0;
      for (int j = 0; j < int'(N); j++) begin
        if (in_s2_q[i*N + j]) begin
          cnt++;
          dec_data[i*B +: B] = B'(j);
        end
      end
      if (cnt != 1) tok_valid = 1'b0;
    end
    neutral = (in_s2_q == '0);
  end

  // RX next state: capture on a full token, release the channel once neutral and consumed.
  always_comb begin
    rx_state_d  = rx_state_q;
    rcv_valid_d = rcv_valid_q;
    rcv_data_d  = rcv_data_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (tok_valid) begin
          rcv_data_d  = dec_data;
          rcv_valid_d = 1'b1;
          rx_state_d  = RxFull;
        end
      end
      RxFull: begin
        if (rcv_valid_q && rcv_ready) rcv_valid_d = 1'b0;
        // Consumption and neutrality may land in the same cycle.
        if (neutral && !rcv_valid_d) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX state register.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      rx_state_q  <= RxIdle;
      rcv_valid_q <= 1'b0;
      rcv_data_q  <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      rcv_valid_q <= rcv_valid_d;
      rcv_data_q  <= rcv_data_d;
    end
  end

  // Encode the latched token one-hot per digit; out-of-range digit values map to rail N-1.
  always_comb begin
    int unsigned dv;
    dv      = 0;
    out_enc = '0;
    for (int i = 0; i < int'(M); i++) begin
      dv = int'(snd_q[i*B +: B]);
      if (dv >= N) dv = N - 1;
      out_enc[i*N + dv] = 1'b1;
    end
  end

  // TX next state: four-phase handshake driven by the synced out_e.
  always_comb begin
    tx_state_d = tx_state_q;
    snd_d      = snd_q;
    out_d_d    = out_d_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (snd_valid) begin
          snd_d      = snd_data;
          tx_state_d = TxWaitE;
        end
      end
      TxWaitE: begin
        if (out_e_s2_q) begin
          out_d_d    = out_enc;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (!out_e_s2_q) begin
          out_d_d    = '0;
          tx_state_d = TxNull;
        end
      end
      TxNull: begin
        if (out_e_s2_q) tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // TX state register; out_d is a flop so all rails of a token switch together.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      tx_state_q <= TxIdle;
      snd_q      <= '0;
      out_d_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      snd_q      <= snd_d;
      out_d_q    <= out_d_d;
    end
  end

`ifdef E1OFN_RAIL_CHECK_EN
  logic multi_hot;
  logic partial_q, partial_d;
  logic rail_err_q, rail_err_d;

  // Flag any synced digit with more than one rail high.
  always_comb begin
    int unsigned hot;
    hot       = 0;
    multi_hot = 1'b0;
    for (int i = 0; i < int'(M); i++) begin
      hot = 0;
      for (int j = 0; j < int'(N); j++) begin
        if (in_s2_q[i*N + j]) hot++;
      end
      if (hot > 1) multi_hot = 1'b1;
    end
  end

  // Track partially arrived tokens while idle; a return to neutral before completion is an error.
  always_comb begin
    partial_d  = partial_q;
    rail_err_d = rail_err_q;
    if (multi_hot) rail_err_d = 1'b1;
    if (rx_state_q == RxIdle) begin
      if (tok_valid) begin
        partial_d = 1'b0;
      end else if (neutral) begin
        if (partial_q) rail_err_d = 1'b1;
        partial_d = 1'b0;
      end else begin
        partial_d = 1'b1;
      end
    end
  end

  // Checker state; rail_err is sticky until reset.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      partial_q  <= 1'b0;
      rail_err_q <= 1'b0;
    end else begin
      partial_q  <= partial_d;
      rail_err_q <= rail_err_d;
    end
  end

  assign rail_err = rail_err_q;
`else
  assign rail_err = 1'b0;
`endif

  assign in_e      = (rx_state_q == RxIdle);
  assign rcv_valid = rcv_valid_q;
  assign rcv_data  = rcv_data_q;
  assign snd_ready = (tx_state_q == TxIdle);
  assign out_d     = out_d_q;

endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// Self-checking bench for e1ofn_rtl_bridge (M=9, N=2): scoreboard queues hold expected RX words
// and TX rail patterns; each scenario task compares inline.
module tb_e1ofn_rtl_bridge;
  localparam int M = 9;
  localparam int N = 2;
  localparam int W = 9;

  logic           CLK = 1'b0;
  logic           rst_n = 1'b0;
  logic [M*N-1:0] in_d = '0;
  logic           in_e;
  logic [W-1:0]   rcv_data;
  logic           rcv_valid;
  logic           rcv_ready = 1'b0;
  logic [W-1:0]   snd_data = '0;
  logic           snd_valid = 1'b0;
  logic           snd_ready;
  logic [M*N-1:0] out_d;
  logic           out_e = 1'b0;
  logic           rail_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   rx_sb[$];
  logic [M*N-1:0] tx_sb[$];

  e1ofn_rtl_bridge #(.M(M), .N(N)) dut (
    .CLK       (CLK),
    ._RESET    (rst_n),
    .in_d      (in_d),
    .in_e      (in_e),
    .rcv_data  (rcv_data),
    .rcv_valid (rcv_valid),
    .rcv_ready (rcv_ready),
    .snd_data  (snd_data),
    .snd_valid (snd_valid),
    .snd_ready (snd_ready),
    .out_d     (out_d),
    .out_e     (out_e),
    .rail_err  (rail_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference dual-rail encoding: bit value selects the rail within each digit.
  function automatic logic [M*N-1:0] enc(input logic [W-1:0] v);
    logic [M*N-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[i*N + (v[i] ? 1 : 0)] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      r = $urandom; in_d = r[M*N-1:0];
      r = $urandom; snd_data = r[W-1:0];
      r = $urandom; snd_valid = r[0]; out_e = r[1]; rcv_ready = r[2];
      tick();
    end
    checks++; if (in_e !== 1'b1) begin errors++; $display("FAIL reset_in_e got %b exp 1", in_e); end
    checks++; if (out_d !== '0) begin errors++; $display("FAIL reset_out_d got %h exp 0", out_d); end
    checks++; if (rcv_valid !== 1'b0) begin errors++; $display("FAIL reset_rcv_valid got %b exp 0", rcv_valid); end
    checks++; if (rcv_data !== '0) begin errors++; $display("FAIL reset_rcv_data got %h exp 0", rcv_data); end
    checks++; if (snd_ready !== 1'b1) begin errors++; $display("FAIL reset_snd_ready got %b exp 1", snd_ready); end
    checks++; if (rail_err !== 1'b0) begin errors++; $display("FAIL reset_rail_err got %b exp 0", rail_err); end
    in_d = '0; snd_valid = 1'b0; snd_data = '0; out_e = 1'b1; rcv_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_receive();
    logic [W-1:0] exp;
    int n;
    rcv_ready = 1'b1;
    in_d = enc(9'h1A5);
    rx_sb.push_back(9'h1A5);
    tick(); tick();
    checks++; if (rcv_valid !== 1'b0) begin errors++; $display("FAIL rx_latency_early rcv_valid got %b exp 0", rcv_valid); end
    tick();
    checks++; if (rcv_valid !== 1'b1) begin errors++; $display("FAIL rx_latency rcv_valid got %b exp 1", rcv_valid); end
    checks++; if (in_e !== 1'b0) begin errors++; $display("FAIL rx_in_e_low got %b exp 0", in_e); end
    if (rcv_valid && rcv_ready) begin
      exp = rx_sb.pop_front();
      checks++; if (rcv_data !== exp) begin errors++; $display("FAIL rx_data got %h exp %h", rcv_data, exp); end
    end
    in_d = '0;
    n = 0;
    while (in_e !== 1'b1 && n < 3) begin tick(); n++; end
    checks++; if (in_e !== 1'b1) begin errors++; $display("FAIL rx_release in_e got %b exp 1", in_e); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    int n;
    rcv_ready = 1'b0;
    in_d = enc(9'h0FF);
    rx_sb.push_back(9'h0FF);
    n = 0;
    while (rcv_valid !== 1'b1 && n < 5) begin tick(); n++; end
    checks++; if (rcv_valid !== 1'b1) begin errors++; $display("FAIL bp_capture rcv_valid got %b exp 1", rcv_valid); end
    in_d = '0;
    repeat (6) tick();
    checks++; if (in_e !== 1'b0) begin errors++; $display("FAIL bp_in_e_held got %b exp 0", in_e); end
    checks++; if (rcv_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b exp 1", rcv_valid); end
    rcv_ready = 1'b1;
    if (rcv_valid && rcv_ready) begin
      exp = rx_sb.pop_front();
      checks++; if (rcv_data !== exp) begin errors++; $display("FAIL bp_data_held got %h exp %h", rcv_data, exp); end
    end
    tick();
    checks++; if (in_e !== 1'b1) begin errors++; $display("FAIL bp_release in_e got %b exp 1", in_e); end
    checks++; if (rcv_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed rcv_valid got %b exp 0", rcv_valid); end
  endtask

  task automatic test_send();
    logic [M*N-1:0] exp;
    int n;
    out_e = 1'b1;
    snd_data = 9'h155;
    snd_valid = 1'b1;
    tx_sb.push_back(enc(9'h155));
    tick();
    snd_valid = 1'b0;
    checks++; if (snd_ready !== 1'b0) begin errors++; $display("FAIL tx_accept snd_ready got %b exp 0", snd_ready); end
    n = 0;
    while (out_d === '0 && n < 4) begin tick(); n++; end
    exp = tx_sb.pop_front();
    checks++; if (out_d !== exp) begin errors++; $display("FAIL tx_data out_d got %h exp %h", out_d, exp); end
    checks++; if (snd_ready !== 1'b0) begin errors++; $display("FAIL tx_busy snd_ready got %b exp 0", snd_ready); end
    out_e = 1'b0;
    n = 0;
    while (out_d !== '0 && n < 4) begin tick(); n++; end
    checks++; if (out_d !== '0) begin errors++; $display("FAIL tx_null out_d got %h exp 0", out_d); end
    checks++; if (snd_ready !== 1'b0) begin errors++; $display("FAIL tx_null_busy snd_ready got %b exp 0", snd_ready); end
    out_e = 1'b1;
    n = 0;
    while (snd_ready !== 1'b1 && n < 4) begin tick(); n++; end
    checks++; if (snd_ready !== 1'b1) begin errors++; $display("FAIL tx_done snd_ready got %b exp 1", snd_ready); end
  endtask

  task automatic test_concurrent_abort();
    logic [W-1:0]   rexp;
    logic [M*N-1:0] texp;
    bit rx_done, tx_done;
    int n;
    rcv_ready = 1'b1;
    out_e = 1'b1;
    in_d = enc(9'h0AA);
    rx_sb.push_back(9'h0AA);
    snd_data = 9'h133;
    snd_valid = 1'b1;
    tx_sb.push_back(enc(9'h133));
    rx_done = 1'b0; tx_done = 1'b0;
    tick();
    snd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!rx_done && rcv_valid && rcv_ready) begin
        rexp = rx_sb.pop_front();
        rx_done = 1'b1;
        checks++; if (rcv_data !== rexp) begin errors++; $display("FAIL conc_rx_data got %h exp %h", rcv_data, rexp); end
      end
      if (!tx_done && out_d !== '0) begin
        texp = tx_sb.pop_front();
        tx_done = 1'b1;
        checks++; if (out_d !== texp) begin errors++; $display("FAIL conc_tx_data got %h exp %h", out_d, texp); end
      end
      tick();
    end
    checks++; if (!(rx_done && tx_done)) begin errors++; $display("FAIL conc_timeout rx_done %b tx_done %b exp 1 1", rx_done, tx_done); end
    in_d = '0;
    out_e = 1'b0;
    n = 0;
    while (!(in_e === 1'b1 && out_d === '0) && n < 6) begin tick(); n++; end
    checks++; if (in_e !== 1'b1 || out_d !== '0) begin errors++; $display("FAIL conc_neutral in_e %b out_d %h exp 1 0", in_e, out_d); end
    out_e = 1'b1;
    n = 0;
    while (snd_ready !== 1'b1 && n < 6) begin tick(); n++; end
    // Abort: reset while the send path is holding a token on the rails.
    snd_data = 9'h0F0;
    snd_valid = 1'b1;
    tx_sb.push_back(enc(9'h0F0));
    tick();
    snd_valid = 1'b0;
    n = 0;
    while (out_d === '0 && n < 6) begin tick(); n++; end
    texp = tx_sb.pop_front();
    checks++; if (out_d !== texp) begin errors++; $display("FAIL abort_tx_data got %h exp %h", out_d, texp); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_d !== '0) begin errors++; $display("FAIL abort_out_d got %h exp 0", out_d); end
    checks++; if (snd_ready !== 1'b1) begin errors++; $display("FAIL abort_snd_ready got %b exp 1", snd_ready); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (out_d !== '0) begin errors++; $display("FAIL abort_discard out_d got %h exp 0", out_d); end
  endtask

  task automatic test_rail_check();
    logic [M*N-1:0] r;
    logic exp_err;
`ifdef E1OFN_RAIL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rcv_ready = 1'b1;
    r = enc(9'h000);
    r[1:0] = 2'b11;
    in_d = r;
    repeat (6) tick();
    checks++; if (rcv_valid !== 1'b0) begin errors++; $display("FAIL multihot_valid got %b exp 0", rcv_valid); end
    checks++; if (in_e !== 1'b1) begin errors++; $display("FAIL multihot_in_e got %b exp 1", in_e); end
    checks++; if (rail_err !== exp_err) begin errors++; $display("FAIL multihot_rail_err got %b exp %b", rail_err, exp_err); end
    in_d = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    // Partial token that returns to neutral without completing.
    in_d = '0;
    in_d[0] = 1'b1;
    repeat (4) tick();
    in_d = '0;
    repeat (4) tick();
    checks++; if (rcv_valid !== 1'b0) begin errors++; $display("FAIL partial_valid got %b exp 0", rcv_valid); end
    checks++; if (rail_err !== exp_err) begin errors++; $display("FAIL partial_rail_err got %b exp %b", rail_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_backpressure();
    test_send();
    test_concurrent_abort();
    test_rail_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
